// File: rtl/cnt_pkg.sv
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared types and elaboration helpers for the up/down counter
//                slice (tick conversion, counter-width helper, direction type).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_pkg;

  // Count direction as seen by the counter datapath
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Number of clock cycles in a period of 'ms' milliseconds
  function automatic int ms_to_ticks(input int f_hz, input int ms);
    return (f_hz / 1000) * ms;
  endfunction

  // Bits needed to hold 0..n-1, never less than one
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler producing a one-cycle count tick per
//                period and a 50% heartbeat LED (high in the first half).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen
  import cnt_pkg::*;
#(
  parameter int F_CLK_HZ = 25_000_000,
  parameter int TICK_MS  = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o,
  output logic led_o
);

  localparam int TICK_TKS = ms_to_ticks(F_CLK_HZ, TICK_MS);

  generate
    if (TICK_TKS <= 1) begin : g_no_prescale
      // A period of one cycle (or less) means every cycle is a tick
      assign tick_o = 1'b1;
      assign led_o  = 1'b1;
    end else begin : g_prescale
      localparam int            PW        = clog2_min1(TICK_TKS);
      localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_TKS - 1);
      localparam logic [PW-1:0] PCNT_HALF = PW'(TICK_TKS / 2);

      logic [PW-1:0] pcnt_q;
      logic [PW-1:0] pcnt_d;

      // Next prescaler value: count up, return to zero after the last cycle
      always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        if (pcnt_q == PCNT_LAST) begin
          pcnt_d = '0;
        end
      end

      // Prescaler register, cleared immediately by reset
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          pcnt_q <= '0;
        end else begin
          pcnt_q <= pcnt_d;
        end
      end

      assign tick_o = (pcnt_q == PCNT_LAST);
      assign led_o  = (pcnt_q < PCNT_HALF);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
//  Module      : updown_counter_mod
//  Description : Modulo-N up/down counter with wrap or saturate ends, preset
//                load, pause with single-step, internal tick prescaler,
//                input synchronisers and cascade outputs (wrap pulse, tc).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_mod
  import cnt_pkg::*;
#(
  parameter int F_CLK_HZ    = 25_000_000,
  parameter int TICK_MS     = 1000,
  parameter int WIDTH       = 6,
  parameter int MODULUS     = 64,
  parameter int SATURATE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pause_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] preset_i,
  output logic             led_o,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o,
  output logic             tc_o
);

  // Reject parameter sets the datapath cannot represent
  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("updown_counter_mod: MODULUS must lie in 2..2**WIDTH");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("updown_counter_mod: SYNC_STAGES must be at least 2");
    end
  endgenerate

  // Comparisons use one extra bit so MODULUS == 2**WIDTH stays representable
  localparam logic [WIDTH:0]   MOD_N    = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   MOD_LAST = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] Q_LAST   = WIDTH'(MODULUS - 1);
  localparam int               N_SYNC   = 4;

  logic              w_tick;
  logic [N_SYNC-1:0] w_async;
  logic [N_SYNC-1:0] w_sync;
  logic              w_pause_s;
  logic              w_up_s;
  logic              w_load_s;
  logic              w_step_s;
  logic              w_step_rise;
  logic              w_adv;
  dir_e              w_dir;
  logic [WIDTH:0]    w_q_ext;
  logic [WIDTH:0]    w_preset_ext;

  logic              step_d_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  q_d;
  logic              wrap_q;
  logic              wrap_d;

  tick_gen #(
    .F_CLK_HZ (F_CLK_HZ),
    .TICK_MS  (TICK_MS)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (w_tick),
    .led_o   (led_o)
  );

  assign w_async = {step_i, load_i, up_i, pause_i};

  generate
    for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;

      // Shift the asynchronous pin through the synchroniser chain
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          chain_q <= '0;
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], w_async[gi]};
        end
      end

      assign w_sync[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  assign w_pause_s    = w_sync[0];
  assign w_up_s       = w_sync[1];
  assign w_load_s     = w_sync[2];
  assign w_step_s     = w_sync[3];
  assign w_step_rise  = w_step_s & ~step_d_q;

  // Ticks count only while running; step edges count only while paused
  assign w_adv        = (w_tick & ~w_pause_s) | (w_step_rise & w_pause_s);
  assign w_dir        = w_up_s ? DIR_UP : DIR_DOWN;
  assign w_q_ext      = {1'b0, q_q};
  assign w_preset_ext = {1'b0, preset_i};

  // Next count: load beats advance; ends either wrap (with pulse) or hold
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (w_load_s) begin
      q_d = (w_preset_ext < MOD_N) ? preset_i : Q_LAST;
    end else if (w_adv) begin
      if (w_dir == DIR_UP) begin
        if (w_q_ext < MOD_LAST) begin
          q_d = q_q + WIDTH'(1);
        end else if (SATURATE == 0) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (w_q_ext > '0) begin
          q_d = q_q - WIDTH'(1);
        end else if (SATURATE == 0) begin
          q_d    = Q_LAST;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Count, wrap pulse and step edge-detect history registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_q      <= '0;
      wrap_q   <= 1'b0;
      step_d_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wrap_q   <= wrap_d;
      step_d_q <= w_step_s;
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;
  assign tc_o   = (w_up_s && (q_q == Q_LAST)) || (!w_up_s && (q_q == '0));

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
//  Module      : tb_updown_counter_mod
//  Description : Directed self-checking bench for updown_counter_mod with a
//                4-cycle tick, 4-bit width and modulus 10, wrap and saturate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic       up;
  logic       load;
  logic       step;
  logic [3:0] preset;
  logic       led, wrap, tc;
  logic [3:0] q;
  logic       led_s, wrap_s, tc_s;
  logic [3:0] q_s;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(
    .F_CLK_HZ(4000), .TICK_MS(1), .WIDTH(4), .MODULUS(10),
    .SATURATE(0), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .pause_i(pause), .up_i(up),
    .load_i(load), .step_i(step), .preset_i(preset),
    .led_o(led), .q_o(q), .wrap_o(wrap), .tc_o(tc)
  );

  updown_counter_mod #(
    .F_CLK_HZ(4000), .TICK_MS(1), .WIDTH(4), .MODULUS(10),
    .SATURATE(1), .SYNC_STAGES(2)
  ) dut_sat (
    .clk_i(clk), .reset_i(reset), .pause_i(pause), .up_i(up),
    .load_i(load), .step_i(step), .preset_i(preset),
    .led_o(led_s), .q_o(q_s), .wrap_o(wrap_s), .tc_o(tc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, ncyc, obs, exp);
    end
  endtask

  task automatic adv_clk();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic run_to(input int n);
    while (ncyc < n) adv_clk();
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; up = 1'b1; load = 1'b0; step = 1'b0; preset = 4'd0;

    // Reset state
    adv_clk();
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_led", led, 1);
    chk("rst_tc", tc, 1);
    chk("rst_q_sat", q_s, 0);
    reset = 1'b0;
    ncyc  = 0;

    // Up count 0..9 -> 0 with wrap; saturating copy holds at 9
    for (int n = 1; n <= 44; n++) begin
      adv_clk();
      chk("up_q", q, (n / 4) % 10);
      chk("up_wrap", wrap, (n == 40));
      chk("led", led, ((n % 4) < 2));
      chk("up_tc", tc, (n < 2) ? 1 : (((n / 4) % 10) == 9));
      chk("sat_q", q_s, ((n / 4) > 9) ? 9 : (n / 4));
      chk("sat_wrap", wrap_s, 0);
      chk("sat_tc", tc_s, ((n < 2) || (n >= 36)));
      chk("sat_led", led_s, ((n % 4) < 2));
    end

    // Load pulse preset 7: q changes three edges after load rises
    preset = 4'd7; load = 1'b1;
    adv_clk();                      // 45
    load = 1'b0;
    chk("ld_e1", q, 1);
    adv_clk(); chk("ld_e2", q, 1);  // 46
    adv_clk(); chk("ld_e3", q, 7);  // 47
    chk("ld_e3_sat", q_s, 7);
    adv_clk(); chk("ld_tick", q, 8); // 48

    // Preset above range clamps to 9; next tick wraps / saturates
    preset = 4'd13; load = 1'b1;
    adv_clk();                      // 49
    load = 1'b0;
    run_to(51);
    chk("clamp_q", q, 9);
    chk("clamp_q_sat", q_s, 9);
    adv_clk();                      // 52
    chk("wrap_up_q", q, 0);
    chk("wrap_up_pulse", wrap, 1);
    chk("sat_up_q", q_s, 9);
    chk("sat_up_wrap", wrap_s, 0);
    chk("sat_up_tc", tc_s, 1);

    // Down from 0: wrap to 9 / saturate at 0
    preset = 4'd0; load = 1'b1; up = 1'b0;
    adv_clk();                      // 53
    load = 1'b0;
    chk("wrap_one_cycle", wrap, 0);
    run_to(55);
    chk("dn_ld_q", q, 0);
    chk("dn_ld_q_sat", q_s, 0);
    adv_clk();                      // 56
    chk("dn_wrap_q", q, 9);
    chk("dn_wrap_pulse", wrap, 1);
    chk("dn_tc", tc, 0);
    chk("dn_sat_q", q_s, 0);
    chk("dn_sat_wrap", wrap_s, 0);
    chk("dn_sat_tc", tc_s, 1);
    run_to(60);
    chk("dn_next_q", q, 8);
    chk("dn_next_q_sat", q_s, 0);
    chk("dn_next_tc_sat", tc_s, 1);

    // Load held across five ticks keeps q at the preset
    up = 1'b1; preset = 4'd7; load = 1'b1;
    run_to(63);
    chk("hold_ld_q", q, 7);
    for (int k = 1; k <= 5; k++) begin
      run_to(60 + 4 * k);
      chk("hold_ld_tick", q, 7);
      chk("hold_ld_tick_sat", q_s, 7);
    end
    load = 1'b0;
    run_to(84);
    chk("hold_rel_q", q, 8);

    // Load coincident with a tick: load wins, tick discarded
    run_to(85);
    load = 1'b1;
    adv_clk();                      // 86
    load = 1'b0;
    run_to(87);
    chk("coin_pre", q, 8);
    adv_clk();                      // 88
    chk("coin_q", q, 7);
    run_to(92);
    chk("coin_next", q, 8);

    // Pause freezes q over 20 ticks
    pause = 1'b1;
    while (ncyc < 174) begin
      adv_clk();
      chk("pause_q", q, 8);
    end

    // Three step pulses, each effective three edges after rising
    step = 1'b1; adv_clk(); step = 1'b0;    // 175
    adv_clk(); chk("st1_pre", q, 8);        // 176
    adv_clk(); chk("st1_q", q, 9);          // 177
    run_to(180);
    step = 1'b1; adv_clk(); step = 1'b0;    // 181
    adv_clk(); chk("st2_pre", q, 9);        // 182
    adv_clk(); chk("st2_q", q, 0);          // 183
    chk("st2_wrap", wrap, 1);
    chk("st2_q_sat", q_s, 9);
    chk("st2_wrap_sat", wrap_s, 0);
    run_to(186);
    step = 1'b1; adv_clk(); step = 1'b0;    // 187
    adv_clk(); chk("st3_pre", q, 0);        // 188
    adv_clk(); chk("st3_q", q, 1);          // 189

    // Step held high ten cycles counts once
    run_to(192);
    step = 1'b1;
    while (ncyc < 202) begin
      adv_clk();
      chk("st_hold_q", q, (ncyc >= 195) ? 2 : 1);
    end
    step = 1'b0;
    while (ncyc < 210) begin
      adv_clk();
      chk("st_rel_q", q, 2);
    end

    // Resume; run up to q=5 with prescaler at 2
    pause = 1'b0;
    run_to(215);
    chk("resume_pre", q, 2);
    adv_clk();
    chk("resume_q", q, 3);
    run_to(226);
    chk("mid_q", q, 5);
    chk("mid_led", led, 0);

    // Asynchronous reset clears state without a clock edge
    #1 reset = 1'b1;
    #1;
    chk("arst_q", q, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_led", led, 1);
    chk("arst_tc", tc, 1);
    chk("arst_q_sat", q_s, 0);
    adv_clk();
    reset = 1'b0;
    ncyc  = 0;
    for (int n = 1; n <= 4; n++) begin
      adv_clk();
      chk("post_rst_q", q, (n == 4) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised successor to the lab's 6-bit preset up/down counter. It provides a modulo-N counter of generic width with selectable wrap or saturate behaviour, synchronous preset load, and pause with single-step. It also has an internal millisecond tick prescaler with heartbeat LED, on-chip input synchronisers, and cascade outputs (`wrap`, `tc`). It sits directly under a board top; that top owns pin-polarity adaptation and drives this block with active-high controls.

## Interface
- `F_CLK_HZ`, 25_000_000: clock frequency in Hz.
- `TICK_MS`, 1000: count-tick period in ms. `TICK_TKS = (F_CLK_HZ/1000)*TICK_MS`.
- `WIDTH`, 6: counter width in bits.
- `MODULUS`, 64: count range `0..MODULUS-1`. Legal range `2..2**WIDTH`; elaboration error otherwise.
- `SATURATE`, 0: 0 = wrap at the ends; 1 = hold at the ends.
- `SYNC_STAGES`, 2: flops per input synchroniser, minimum 2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset of all state.
- `pause`  in  1  async level; 1 = tick counting suspended.
- `up`  in  1  async level; 1 = count up, 0 = count down.
- `load`  in  1  async level, active-high; loads `preset`.
- `step`  in  1  async; each rising edge advances one count while paused.
- `preset`  in  WIDTH  quasi-static switch value; sampled only while `load` is active.
- `led`  out  1  heartbeat, high for the first half of each tick period.
- `q`  out  WIDTH  registered count.
- `wrap`  out  1  registered one-cycle pulse when a wrap occurs.
- `tc`  out  1  terminal count level: (`up_s` and `q==MODULUS-1`) or (!`up_s` and `q==0`).

## Operation
- Prescaler: `pcnt` runs 0..`TICK_TKS-1`, then returns to 0.
  - `tick` = (`pcnt==TICK_TKS-1`). If `TICK_TKS<=1`, `tick` = 1 every cycle.
  - `led` = (`pcnt < TICK_TKS/2`). If `TICK_TKS<=1`, `led` = 1.
  - The prescaler free-runs and is unaffected by `pause`, `load` or `step`.
- Synchronisers: `pause`, `up`, `load` and `step` each pass through `SYNC_STAGES` flops, giving `*_s`. `step_d` is `step_s` delayed by one cycle; `step_rise` = `step_s & ~step_d`.
- Advance: `adv` = (`tick` & ~`pause_s`) | (`step_rise` & `pause_s`).
  - Step edges while not paused are ignored.
  - Ticks while paused are ignored.
- Priority per clock edge: `reset` > `load_s` > `adv`.
- Load: `q <= preset` if `preset < MODULUS`, else `q <= MODULUS-1` (clamp). `wrap <= 0`.
  - A coincident advance is discarded, not deferred.
  - Load held active keeps `q` at the preset.
- Up advance:
  - If `q < MODULUS-1`: `q+1`.
  - At `MODULUS-1`: wrap mode gives `q <= 0` and `wrap <= 1`; saturate mode holds `q` with `wrap <= 0`.
- Down advance:
  - If `q > 0`: `q-1`.
  - At 0: wrap mode gives `q <= MODULUS-1` and `wrap <= 1`; saturate mode holds `q` with `wrap <= 0`.
- `wrap` is 0 in every cycle without a wrapping advance.
- Arithmetic is done at WIDTH+1 bits internally, so `MODULUS == 2**WIDTH` compares correctly. No reliance on natural overflow.
- Direction changes apply to the next advance. `tc` follows `up_s` combinationally from registered state.

## Timing
- Reset values: `q`=0, `wrap`=0, `pcnt`=0 (so `led`=1), all synchroniser flops 0 (so `up_s`=0 and `tc`=1).
- Reset assertion clears state immediately, without waiting for a clock edge.
- After release, the first `tick` occurs on the `TICK_TKS`-th clock edge.
- Input pin to `q` change:
  - `load`: SYNC_STAGES+1 edges.
  - `step`: SYNC_STAGES+1 edges after the rising edge.
  - `up` and `pause` take effect from SYNC_STAGES edges after their change.
- `wrap` is asserted in the same cycle that `q` shows the wrapped value.
- `step` held high counts once. A step pulse shorter than one clock may be missed; board buttons are far longer than that.

## Structure
- Package `cnt_pkg` holds:
  - function `ms_to_ticks(f_hz, ms)`;
  - localparam helper `clog2_min1`;
  - `typedef enum logic {DIR_DOWN, DIR_UP} dir_e`.
- Sub-module `tick_gen` (params `F_CLK_HZ`, `TICK_MS`; outputs `tick`, `led`) contains the prescaler. Synchronisers are a generate loop in the top of this block.

## Test plan
Bench parameters: `F_CLK_HZ`=4000, `TICK_MS`=1 (`TICK_TKS`=4), `WIDTH`=4, `MODULUS`=10, `SYNC_STAGES`=2.
- Up count, wrap mode: `up`=1, `pause`=0 after reset → `q` steps 0..9 then 0, one step per 4 clocks. `wrap` is high for exactly one cycle at 9→0. `led` is high for 2 of every 4 cycles.
- Down boundary: `up`=0 from `q`=0 → `q`=9 with a `wrap` pulse. With `SATURATE`=1, `q` stays 0, `wrap` stays 0 and `tc` stays 1.
- Load:
  - `preset`=7 pulse → `q`=7 three edges after `load` rises.
  - `preset`=13 → `q`=9.
  - `load` held across 5 ticks → `q` remains 7.
  - Load coincident with a tick → `q`=7, and the next tick gives 8.
- Pause/step: `pause`=1 → `q` frozen over 20 ticks. Three `step` pulses → `q` +3, each change 3 edges after the rising edge. `step` held high 10 cycles → +1 only.
- Reset mid-run: assert `reset` at `q`=5 with `pcnt`=2 → `q`=0, `wrap`=0, `led`=1 without a clock edge. After release, the first increment occurs on the 4th edge.
